seg7_scan: RTL

Four-digit, time-multiplexed seven-segment driver that sits directly downstream of the board-level manager. It consumes the manager's 20-bit `disp` word (four 5-bit glyph codes) plus a per-digit decimal-point mask, latches it once per scan frame to prevent tearing, decodes each glyph and drives active-low segment and anode pins with a blanking dead time between digits.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_scan_if.sv | 12 +
 rtl/seg7_glyph.sv | 47 ++++
 rtl/seg7_scan.sv | 100 ++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph codes and active-low segment patterns ({g,f,e,d,c,b,a}) for the
// display path; also used by the manager and its text producers.
package seg7_pkg;

  localparam logic [4:0] G_H     = 5'd16;
  localparam logic [4:0] G_L     = 5'd17;
  localparam logic [4:0] G_P     = 5'd18;
  localparam logic [4:0] G_O     = 5'd19;
  localparam logic [4:0] G_N     = 5'd20;
  localparam logic [4:0] G_U     = 5'd21;
  localparam logic [4:0] G_Y     = 5'd22;
  localparam logic [4:0] G_MINUS = 5'd23;
  localparam logic [4:0] G_UNDER = 5'd24;
  localparam logic [4:0] G_R     = 5'd25;
  localparam logic [4:0] G_T     = 5'd26;
  localparam logic [4:0] G_C     = 5'd27;
  localparam logic [4:0] G_I     = 5'd28;
  localparam logic [4:0] G_J     = 5'd29;
  localparam logic [4:0] G_EQ    = 5'd30;
  localparam logic [4:0] G_BLANK = 5'd31;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus between the board manager (master) and the scan driver (slave).
interface seg7_scan_if;
  logic [19:0] disp;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame;

  modport master (output disp, output dp, input seg, input dp_n, input an, input frame);
  modport slave  (input disp, input dp, output seg, output dp_n, output an, output frame);
endinterface

// File: rtl/seg7_glyph.sv
// Combinational glyph decoder: 5-bit code to active-low {g,f,e,d,c,b,a}.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:    seg = SEG_0;
      5'd1:    seg = 7'h79;
      5'd2:    seg = 7'h24;
      5'd3:    seg = 7'h30;
      5'd4:    seg = 7'h19;
      5'd5:    seg = 7'h12;
      5'd6:    seg = 7'h02;
      5'd7:    seg = 7'h78;
      5'd8:    seg = SEG_8;
      5'd9:    seg = 7'h10;
      5'd10:   seg = 7'h08;
      5'd11:   seg = 7'h03;
      5'd12:   seg = 7'h46;
      5'd13:   seg = 7'h21;
      5'd14:   seg = SEG_E;
      5'd15:   seg = 7'h0E;
      G_H:     seg = 7'h09;
      G_L:     seg = 7'h47;
      G_P:     seg = 7'h0C;
      G_O:     seg = 7'h23;
      G_N:     seg = 7'h2B;
      G_U:     seg = 7'h41;
      G_Y:     seg = 7'h11;
      G_MINUS: seg = SEG_MINUS;
      G_UNDER: seg = 7'h77;
      G_R:     seg = SEG_R;
      G_T:     seg = 7'h07;
      G_C:     seg = 7'h27;
      G_I:     seg = 7'h7B;
      G_J:     seg = 7'h61;
      G_EQ:    seg = 7'h37;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: per-frame input latch, per-digit
// dead time, registered active-low segment/anode outputs.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIV  = 50000,
  parameter int unsigned DEAD = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_scan_if.slave bus
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [19:0]   frame_disp;
  logic [3:0]    frame_dp;
  logic [4:0]    cur_code;
  logic [6:0]    cur_seg;
  logic          cur_dp;
  logic          latch_en;
  logic [6:0]    seg_q;
  logic          dp_n_q;
  logic [3:0]    an_q;
  logic          frame_q;

  assign latch_en = (cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame registers only move at the top of digit 0, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_disp <= {4{G_BLANK}};
      frame_dp   <= 4'h0;
    end else if (latch_en) begin
      frame_disp <= bus.disp;
      frame_dp   <= bus.dp;
    end
  end

  always_comb begin
    cur_code = G_BLANK;
    case (idx)
      2'd0: cur_code = frame_disp[19:15];
      2'd1: cur_code = frame_disp[14:10];
      2'd2: cur_code = frame_disp[9:5];
      2'd3: cur_code = frame_disp[4:0];
      default: cur_code = G_BLANK;
    endcase
  end

  // Digit 0 owns the MSB of dp and an, so the slot bit is ~idx.
  assign cur_dp = frame_dp[~idx];

  seg7_glyph u_glyph (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
      dp_n_q  <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= latch_en;
      if (cnt < DEAD_C) begin
        an_q   <= 4'hF;
        seg_q  <= SEG_BLANK;
        dp_n_q <= 1'b1;
      end else begin
        an_q   <= ~(4'b1000 >> idx);
        seg_q  <= cur_seg;
        dp_n_q <= ~cur_dp;
      end
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp_n  = dp_n_q;
  assign bus.frame = frame_q;

endmodule
